// File: rtl/retire_trace_buffer.sv
// Purpose: captures retired-instruction records in a FIFO for a trace consumer, and detects the
//          end-of-program syscall (instr 0xC with $v0 = 10) so it can drain the buffer and then halt.
// Latency: a push into an empty buffer shows on trace_* one cycle later (first-word-fall-through).
// Backpressure: trace_valid/trace_ready handshake on the output. The retire side cannot be stalled,
//               so a retire into a full buffer with no pop is dropped and sets sticky overflow.
// Ports:
//   clk, reset (synchronous, active high)
//   ret_valid, ret_pc, ret_instr, ret_wr_en, ret_wr_reg, ret_wr_data : retiring instruction record
//   v0_val : register $2 contents before this cycle's write; used for exit-syscall detection
//   trace_valid, trace_ready, trace_pc, trace_instr, trace_wr_en, trace_wr_reg, trace_wr_data : head record
//   level : current occupancy (0..DEPTH)
//   retired : count of accepted records (wraps)
//   overflow : sticky, a record was dropped
//   halt : exit syscall retired and the buffer has fully drained

// Purpose: generic single-clock FIFO; storage is not reset, pointers and count are.
// Latency: head_dat reflects a push into an empty FIFO one cycle after the push edge.
// Backpressure: none inside; the caller must not push when full unless it also pops.
module rtb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   // DEPTH is a power of two, so pointers wrap naturally at AW bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // When full with push+pop, wr_ptr == rd_ptr: the old head is read out on this edge
   // and the slot is refilled, so the head never changes under a stalled consumer.
   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
   assign level    = count;
endmodule

module retire_trace_buffer #(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ret_valid,
   input  logic [31:0]            ret_pc,
   input  logic [31:0]            ret_instr,
   input  logic                   ret_wr_en,
   input  logic [4:0]             ret_wr_reg,
   input  logic [31:0]            ret_wr_data,
   input  logic [31:0]            v0_val,
   output logic                   trace_valid,
   input  logic                   trace_ready,
   output logic [31:0]            trace_pc,
   output logic [31:0]            trace_instr,
   output logic                   trace_wr_en,
   output logic [4:0]             trace_wr_reg,
   output logic [31:0]            trace_wr_data,
   output logic [$clog2(DEPTH):0] level,
   output logic [31:0]            retired,
   output logic                   overflow,
   output logic                   halt
);
   localparam int LW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        wr_en;
      logic [4:0]  wr_reg;
      logic [31:0] wr_data;
   } rec_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   rec_t   in_rec;
   rec_t   head_rec;
   logic   full;
   logic   ret_ok;
   logic   push;
   logic   pop;
   logic   drop;
   logic   is_exit;

   assign in_rec = '{pc:      ret_pc,
                     instr:   ret_instr,
                     wr_en:   ret_wr_en,
                     wr_reg:  ret_wr_reg,
                     wr_data: ret_wr_data};

   assign full        = (level == LW'(DEPTH));
   assign trace_valid = (level != '0);

   // Reset wins over everything: no pop reported and no retire accepted in a reset cycle.
   assign pop     = trace_valid & trace_ready & ~reset;
   assign ret_ok  = ret_valid & ~reset & (state == RUN);
   assign push    = ret_ok & (~full | pop);
   assign drop    = ret_ok & full & ~pop;
   assign is_exit = (ret_instr == 32'h0000_000C) && (v0_val == 32'h0000_000A);

   rtb_fifo #(
      .WIDTH ($bits(rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (in_rec),
      .pop      (pop),
      .head_dat (head_rec),
      .level    (level)
   );

   assign trace_pc      = head_rec.pc;
   assign trace_instr   = head_rec.instr;
   assign trace_wr_en   = trace_valid & head_rec.wr_en;
   assign trace_wr_reg  = head_rec.wr_reg;
   assign trace_wr_data = head_rec.wr_data;

   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         // Exit is taken even if the syscall record itself was dropped on a full buffer.
         RUN:     if (ret_ok && is_exit) state_nxt = DRAIN;
         // Halt on the edge where occupancy reaches zero (no pushes happen in DRAIN).
         DRAIN:   if ((level == '0) || ((level == LW'(1)) && pop)) state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retired  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) retired  <= retired + 32'd1;
         if (drop) overflow <= 1'b1;
      end
   end

   assign halt = (state == HALTED);
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Purpose: self-checking bench for retire_trace_buffer: vector table plus multi-cycle sequences,
//          with a record scoreboard filled at push time and drained at each output handshake.
// Latency: one clock per applied vector; outputs sampled 1 ns after the rising edge.
// Backpressure: trace_ready driven per vector/sequence to exercise stall, stream and drain.
module tb_retire_trace_buffer;
   localparam int DEPTH = 8;
   localparam int S_RUN = 0, S_DRAIN = 1, S_HALTED = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        ret_valid;
   logic [31:0] ret_pc, ret_instr, ret_wr_data, v0_val;
   logic        ret_wr_en;
   logic [4:0]  ret_wr_reg;
   logic        trace_valid, trace_ready, trace_wr_en;
   logic [31:0] trace_pc, trace_instr, trace_wr_data;
   logic [4:0]  trace_wr_reg;
   logic [3:0]  level;
   logic [31:0] retired;
   logic        overflow, halt;

   always #5 clk = ~clk;

   retire_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
      .ret_wr_en(ret_wr_en), .ret_wr_reg(ret_wr_reg), .ret_wr_data(ret_wr_data), .v0_val(v0_val),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
      .trace_instr(trace_instr), .trace_wr_en(trace_wr_en), .trace_wr_reg(trace_wr_reg),
      .trace_wr_data(trace_wr_data), .level(level), .retired(retired), .overflow(overflow),
      .halt(halt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        wr_en;
      logic [4:0]  wr_reg;
      logic [31:0] wr_data;
   } rec_t;

   typedef struct {
      logic        rv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  rg;
      logic [31:0] wd;
      logic [31:0] v0;
      logic        rdy;
      logic        e_valid;
      int          e_level;
      int          e_retired;
      logic        e_ovf;
      logic        e_halt;
      logic [31:0] e_pc;
      logic [31:0] e_data;
   } vec_t;

   rec_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_level;
   int          exp_state;
   logic [31:0] exp_retired;
   logic        exp_ovf;
   logic [31:0] next_pc;
   vec_t        tbl[11];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic we, input logic [4:0] rg, input logic [31:0] wd,
                      input logic [31:0] v0, input logic rdy);
      ret_valid = v; ret_pc = pc; ret_instr = instr; ret_wr_en = we;
      ret_wr_reg = rg; ret_wr_data = wd; v0_val = v0; trace_ready = rdy;
   endtask

   // One clock: the reference model decides push/pop/drop from the spec rules and its own
   // occupancy, scores the popped head, then checks the visible status after the edge.
   task automatic cycle();
      rec_t cur;
      rec_t exp_rec;
      logic run_m, pop_m, push_m, drop_m, exit_m;
      cur    = '{pc: ret_pc, instr: ret_instr, wr_en: ret_wr_en, wr_reg: ret_wr_reg, wr_data: ret_wr_data};
      run_m  = (exp_state == S_RUN);
      exit_m = (ret_instr == 32'h0000_000C) && (v0_val == 32'h0000_000A);
      pop_m  = !reset && trace_ready && (exp_level > 0);
      push_m = !reset && ret_valid && run_m && ((exp_level < DEPTH) || pop_m);
      drop_m = !reset && ret_valid && run_m && (exp_level == DEPTH) && !pop_m;
      if (pop_m) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow: actual pop required none");
         end else begin
            exp_rec = sb.pop_front();
            chk("pop_record", {trace_pc, trace_instr, trace_wr_en, trace_wr_reg, trace_wr_data}, exp_rec);
         end
      end
      if (push_m) sb.push_back(cur);
      @(posedge clk);
      #1;
      if (reset) begin
         exp_level = 0; exp_retired = '0; exp_ovf = 1'b0; exp_state = S_RUN;
         sb.delete();
      end else begin
         if (push_m && !pop_m) exp_level++;
         else if (pop_m && !push_m) exp_level--;
         if (push_m) exp_retired = exp_retired + 32'd1;
         if (drop_m) exp_ovf = 1'b1;
         if (run_m && ret_valid && exit_m) exp_state = S_DRAIN;
         else if (exp_state == S_DRAIN && exp_level == 0) exp_state = S_HALTED;
      end
      chk("level", level, exp_level);
      chk("retired", retired, exp_retired);
      chk("overflow", overflow, exp_ovf);
      chk("halt", halt, exp_state == S_HALTED);
      chk("trace_valid", trace_valid, exp_level > 0);
   endtask

   task automatic idle(input logic rdy);
      drv(1'b0, '0, '0, 1'b0, '0, '0, '0, rdy);
   endtask

   task automatic push_rec(input logic rdy);
      drv(1'b1, next_pc, 32'h2000_0000 | 32'($urandom_range(0, 16'hFFFF)), 1'b1,
          5'($urandom_range(1, 31)), $urandom, 32'($urandom_range(0, 9)), rdy);
      next_pc = next_pc + 32'd4;
      cycle();
   endtask

   task automatic push_exit(input logic rdy);
      drv(1'b1, next_pc, 32'h0000_000C, 1'b0, 5'd0, 32'd0, 32'h0000_000A, rdy);
      next_pc = next_pc + 32'd4;
      cycle();
   endtask

   // ret_valid and trace_ready are held high to show both are ignored during reset.
   task automatic do_reset();
      reset = 1'b1;
      drv(1'b1, 32'hDEAD_0000, 32'h2402_0001, 1'b1, 5'd3, 32'h1234, 32'h0, 1'b1);
      cycle();
      reset = 1'b0;
      idle(1'b0);
   endtask

   initial begin
      reset = 1'b1; exp_level = 0; exp_state = S_RUN; exp_retired = '0; exp_ovf = 1'b0;
      next_pc = 32'h0040_1000;
      idle(1'b0);

      //          rv   pc            instr         we   rg    wd     v0     rdy  val  lvl ret ovf halt  head pc       head data
      tbl[0]  = '{1'b1, 32'h00400000, 32'h24020005, 1'b1, 5'd2, 32'h5,  32'h0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 32'h00400000, 32'h5};
      tbl[1]  = '{1'b1, 32'h00400004, 32'h24040004, 1'b1, 5'd4, 32'h11, 32'h5, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0, 32'h00400000, 32'h5};
      tbl[2]  = '{1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,  32'h0, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0, 32'h00400000, 32'h5};
      tbl[3]  = '{1'b1, 32'h00400008, 32'h0000000C, 1'b0, 5'd0, 32'h22, 32'h4, 1'b0, 1'b1, 3, 3, 1'b0, 1'b0, 32'h00400000, 32'h5};
      tbl[4]  = '{1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,  32'h0, 1'b1, 1'b1, 2, 3, 1'b0, 1'b0, 32'h00400004, 32'h11};
      tbl[5]  = '{1'b1, 32'h0040000C, 32'h24050007, 1'b1, 5'd5, 32'h33, 32'h4, 1'b1, 1'b1, 2, 4, 1'b0, 1'b0, 32'h00400008, 32'h22};
      tbl[6]  = '{1'b1, 32'h00400010, 32'h2402000A, 1'b1, 5'd2, 32'hA,  32'hA, 1'b0, 1'b1, 3, 5, 1'b0, 1'b0, 32'h00400008, 32'h22};
      tbl[7]  = '{1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,  32'h0, 1'b1, 1'b1, 2, 5, 1'b0, 1'b0, 32'h0040000C, 32'h33};
      tbl[8]  = '{1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,  32'h0, 1'b1, 1'b1, 1, 5, 1'b0, 1'b0, 32'h00400010, 32'hA};
      tbl[9]  = '{1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,  32'h0, 1'b1, 1'b0, 0, 5, 1'b0, 1'b0, 32'h0,        32'h0};
      tbl[10] = '{1'b0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0,  32'h0, 1'b1, 1'b0, 0, 5, 1'b0, 1'b0, 32'h0,        32'h0};

      // Reset state
      do_reset();
      chk("rst_trace_valid", trace_valid, 1'b0);
      chk("rst_level", level, 0);
      chk("rst_retired", retired, 0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_halt", halt, 1'b0);
      chk("rst_trace_wr_en", trace_wr_en, 1'b0);

      // Vector table: single push, stall stability, non-exit syscalls, push+pop, drain to empty
      foreach (tbl[i]) begin
         drv(tbl[i].rv, tbl[i].pc, tbl[i].instr, tbl[i].we, tbl[i].rg, tbl[i].wd, tbl[i].v0, tbl[i].rdy);
         cycle();
         chk($sformatf("vec%0d_valid", i), trace_valid, tbl[i].e_valid);
         chk($sformatf("vec%0d_level", i), level, tbl[i].e_level);
         chk($sformatf("vec%0d_retired", i), retired, tbl[i].e_retired);
         chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].e_ovf);
         chk($sformatf("vec%0d_halt", i), halt, tbl[i].e_halt);
         if (tbl[i].e_valid) begin
            chk($sformatf("vec%0d_pc", i), trace_pc, tbl[i].e_pc);
            chk($sformatf("vec%0d_data", i), trace_wr_data, tbl[i].e_data);
         end
      end
      idle(1'b0);

      // Fill and overflow, then drain in order
      do_reset();
      repeat (9) push_rec(1'b0);
      chk("fill_level", level, 8);
      chk("fill_overflow", overflow, 1'b1);
      chk("fill_retired", retired, 8);
      idle(1'b1);
      repeat (8) cycle();
      chk("fill_drained", level, 0);

      // Full buffer streaming with simultaneous push+pop; pointers wrap several times
      do_reset();
      repeat (8) push_rec(1'b0);
      repeat (20) push_rec(1'b1);
      chk("stream_level", level, 8);
      chk("stream_overflow", overflow, 1'b0);
      chk("stream_retired", retired, 28);
      idle(1'b1);
      repeat (8) cycle();
      chk("stream_drained", level, 0);

      // Exit syscall: drain then halt exactly when the last record leaves
      do_reset();
      repeat (3) push_rec(1'b0);
      push_exit(1'b0);
      chk("exit_level", level, 4);
      repeat (3) push_rec(1'b0);
      chk("drain_ignored_level", level, 4);
      chk("drain_ignored_retired", retired, 4);
      chk("drain_no_overflow", overflow, 1'b0);
      idle(1'b1);
      repeat (3) cycle();
      chk("drain_halt_early", halt, 1'b0);
      cycle();
      chk("drain_halt", halt, 1'b1);
      chk("drain_level0", level, 0);
      repeat (2) push_rec(1'b1);
      chk("halted_terminal", halt, 1'b1);
      chk("halted_ignores", retired, 4);

      // Exit syscall dropped on a full buffer still enters DRAIN
      do_reset();
      repeat (8) push_rec(1'b0);
      push_exit(1'b0);
      chk("exitfull_overflow", overflow, 1'b1);
      chk("exitfull_retired", retired, 8);
      push_rec(1'b0);
      chk("exitfull_ignored", retired, 8);
      idle(1'b1);
      repeat (8) cycle();
      chk("exitfull_halt", halt, 1'b1);

      // Reset in the middle of a drain
      do_reset();
      repeat (4) push_rec(1'b0);
      push_exit(1'b0);
      chk("middrain_level", level, 5);
      push_rec(1'b0);
      do_reset();
      chk("middrain_rst_level", level, 0);
      chk("middrain_rst_valid", trace_valid, 1'b0);
      chk("middrain_rst_halt", halt, 1'b0);
      chk("middrain_rst_ovf", overflow, 1'b0);
      chk("middrain_rst_retired", retired, 0);
      push_rec(1'b0);
      chk("middrain_run_level", level, 1);
      chk("middrain_run_retired", retired, 1);
      idle(1'b1);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >= 2).
REQ-002 The block SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset input 1: synchronous, active-high reset.
REQ-004 The block SHALL have port ret_valid input 1: the CPU retires one instruction this cycle.
REQ-005 The block SHALL have port ret_pc input 32: PC of the retiring instruction.
REQ-006 The block SHALL have port ret_instr input 32: encoding of the retiring instruction.
REQ-007 The block SHALL have port ret_wr_en input 1: the retiring instruction writes the register file, including link writes.
REQ-008 The block SHALL have port ret_wr_reg input 5: destination register index, with 31 for links.
REQ-009 The block SHALL have port ret_wr_data input 32: value written to ret_wr_reg.
REQ-010 The block SHALL have port v0_val input 32: current register $2 contents, pre-write for this cycle.
REQ-011 The block SHALL have port trace_valid output 1: head record is available.
REQ-012 The block SHALL have port trace_ready input 1: consumer accepts the head record.
REQ-013 The block SHALL have port trace_pc, trace_instr, trace_wr_en, trace_wr_reg and trace_wr_data outputs (32/32/1/5/32): head record fields.
REQ-014 The block SHALL have port level output clog2(DEPTH)+1: current occupancy.
REQ-015 The block SHALL have port retired output 32: count of accepted records.
REQ-016 The block SHALL have port overflow output 1: sticky flag, set when a record was dropped.
REQ-017 The block SHALL have port halt output 1: sticky flag, set when the end-of-program syscall retired and the buffer has fully drained.

Function
REQ-018 A push SHALL occur when ret_valid=1 and state is RUN and (level<DEPTH, or a pop occurs in the same cycle).
REQ-019 A pop SHALL occur when trace_valid=1 and trace_ready=1.
REQ-020 The FIFO SHALL be first-word-fall-through: a record pushed into an empty FIFO at edge N SHALL appear on trace_* with trace_valid=1 after edge N, i.e. one cycle latency.
REQ-021 Simultaneous push and pop SHALL leave level unchanged; level SHALL equal pushes minus pops since reset, in the range 0..DEPTH.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH with no skipped or duplicated entries.
REQ-023 trace_* data SHALL stay stable while trace_valid=1 and trace_ready=0.
REQ-024 ret_valid=1 in RUN with level=DEPTH and no pop SHALL drop the record, set overflow=1, and leave FIFO contents, level and retired unchanged.
REQ-025 retired SHALL increment by 1 on each push and wrap from 0xFFFFFFFF to 0.
REQ-026 The block SHALL implement a state machine with states RUN, DRAIN and HALTED.
REQ-027 RUN->DRAIN SHALL occur on an accepted push with ret_instr=32'h0000000C and v0_val=32'h0000000A; this syscall record is itself pushed.
REQ-028 If the exit syscall coincides with a full FIFO and no pop, the record SHALL be dropped, overflow SHALL be set, and DRAIN SHALL still be entered.
REQ-029 In DRAIN and HALTED, ret_valid SHALL be ignored, with no push and no overflow.
REQ-030 DRAIN->HALTED SHALL occur on the edge where level becomes 0, or is already 0; halt=1 in HALTED only.
REQ-031 HALTED SHALL be terminal until reset.
REQ-032 A syscall 0xC with v0_val != 10 SHALL be an ordinary record.

Reset
REQ-033 Reset=1 at a rising edge SHALL return the state to RUN and set level=0, pointers=0, retired=0, overflow=0, halt=0 and trace_valid=0.
REQ-034 trace_pc, trace_instr, trace_wr_reg and trace_wr_data SHALL be don't-care while trace_valid=0; trace_wr_en SHALL be 0 after reset.
REQ-035 Reset mid-operation, in any state with any level, SHALL discard all stored records, and no pop SHALL be reported in that cycle.
REQ-036 ret_valid SHALL be ignored in the cycle reset=1.

Verification
REQ-037 Single push: ret_valid=1, pc=0x00400000, instr=0x24020005, wr_en=1, reg=2, data=5, trace_ready=0 -> next cycle trace_valid=1, trace_pc=0x00400000, trace_wr_data=5, level=1, retired=1.
REQ-038 Fill and overflow (DEPTH=8): 9 consecutive pushes, trace_ready=0 -> level=8, overflow=1, retired=8; then 8 pops return pc values in push order and level reaches 0.
REQ-039 Full with simultaneous push+pop: level=8, ret_valid=1 and trace_ready=1 in the same cycle -> level stays 8, overflow stays 0, pointer wrap is exercised with 20 streamed records in order.
REQ-040 Exit: 3 records buffered, then instr=0x0000000C with v0_val=0xA -> state DRAIN, later ret_valid ignored; after 4 pops halt=1 on the edge where level becomes 0.
REQ-041 Non-exit syscall: instr=0xC with v0_val=4 -> pushed normally, state RUN, halt=0.
REQ-042 Reset mid-drain: reset=1 for one cycle with level=5 in DRAIN -> level=0, trace_valid=0, halt=0, overflow=0, retired=0, state RUN.
